param_register: RTL

PARAM_REGISTER -- requirements
Module: param_register

---
 rtl/param_register.sv | 131 +++++++++++++
 1 files changed

// File: rtl/param_register.sv
// -----------------------------------------------------------------------------
// param_register
// Parameterised accumulator-style register with an E (extend/carry) flag.
// Each cycle it executes one data operation. The fixed priority is
// ld > clr > inc > dec > shr > shl > cmp. An E-flag operation
// (e_clr > e_cmp) can accompany ld, clr or cmp.
//
// Parameters
//   WIDTH     register width in bits (legal range 2..64)
//   RESET_VAL value loaded on reset, truncated to WIDTH bits
//   SATURATE  0 = wrap-around inc/dec, 1 = saturating inc/dec
//
// Ports
//   clk       sole clock, rising edge
//   reset     asynchronous, active-high reset
//   data_in   parallel load value
//   ld, clr, inc, dec, shr, shl, cmp   data-operation strobes (level)
//   e_clr, e_cmp                       E-flag operation strobes (level)
//   data_out  register contents (flop output)
//   e_out     E flag (flop output)
//   zero      combinational decode: data_out == 0
// -----------------------------------------------------------------------------
module param_register #(
    parameter int unsigned WIDTH     = 16,
    parameter logic [63:0] RESET_VAL = 64'd0,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    input  logic             shr,
    input  logic             shl,
    input  logic             cmp,
    input  logic             e_clr,
    input  logic             e_cmp,
    output logic [WIDTH-1:0] data_out,
    output logic             e_out,
    output logic             zero
);

    localparam logic [WIDTH-1:0] L_RESET = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] L_ONES  = '1;
    localparam logic [WIDTH-1:0] L_ONE   = WIDTH'(1);

    logic [WIDTH-1:0] r_data;
    logic             r_e;

    logic [WIDTH-1:0] w_data_nxt;
    logic             w_e_nxt;
    logic             w_e_ops_en;
    logic [WIDTH:0]   w_inc_sum;
    logic [WIDTH-1:0] w_dec_diff;
    logic             w_at_max;
    logic             w_at_min;

    // Arithmetic datapath: the carry of the WIDTH+1 bit sum is the inc E value
    assign w_inc_sum  = {1'b0, r_data} + (WIDTH+1)'(1);
    assign w_dec_diff = r_data - L_ONE;
    assign w_at_max   = (r_data == L_ONES);
    assign w_at_min   = (r_data == '0);

    // Next-state selection: a priority chain so only one data operation wins
    always_comb begin
        w_data_nxt = r_data;
        w_e_nxt    = r_e;
        w_e_ops_en = 1'b1;

        if (ld) begin
            w_data_nxt = data_in;
        end else if (clr) begin
            w_data_nxt = '0;
        end else if (inc) begin
            w_e_ops_en = 1'b0;
            if (SATURATE && w_at_max) begin
                w_data_nxt = r_data;
                w_e_nxt    = 1'b1;
            end else begin
                w_data_nxt = w_inc_sum[WIDTH-1:0];
                w_e_nxt    = w_inc_sum[WIDTH];
            end
        end else if (dec) begin
            w_e_ops_en = 1'b0;
            // Borrow only when decrementing from zero
            w_e_nxt    = w_at_min;
            if (SATURATE && w_at_min) begin
                w_data_nxt = r_data;
            end else begin
                w_data_nxt = w_dec_diff;
            end
        end else if (shr) begin
            w_e_ops_en = 1'b0;
            w_data_nxt = {r_e, r_data[WIDTH-1:1]};
            w_e_nxt    = r_data[0];
        end else if (shl) begin
            w_e_ops_en = 1'b0;
            w_data_nxt = {r_data[WIDTH-2:0], r_e};
            w_e_nxt    = r_data[WIDTH-1];
        end else if (cmp) begin
            w_data_nxt = ~r_data;
        end

        // E-flag operations only when the data op leaves E alone
        if (w_e_ops_en) begin
            if (e_clr) begin
                w_e_nxt = 1'b0;
            end else if (e_cmp) begin
                w_e_nxt = ~r_e;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= L_RESET;
            r_e    <= 1'b0;
        end else begin
            r_data <= w_data_nxt;
            r_e    <= w_e_nxt;
        end
    end

    assign data_out = r_data;
    assign e_out    = r_e;
    assign zero     = (r_data == '0);

endmodule
